// File: rtl/hnm_request_arbiter.sv
// hnm_request_arbiter: round-robin sharing of one HNM pattern memory between NREQ requesters,
// with write-row hazard blocking and a fixed-latency read tag pipeline. Stats via HNM_ARB_STATS_EN.
module hnm_request_arbiter #(
    parameter int NREQ          = 4,
    parameter int SSIDBITS      = 12,
    parameter int ROWBITS       = 7,
    parameter int READ_LATENCY  = 4,
    parameter int HAZARD_WINDOW = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ-1:0]          req_write_i,
    input  logic [NREQ*SSIDBITS-1:0] req_ssid_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic [NREQ-1:0]          resp_valid_o,
    output logic [SSIDBITS-1:0]      resp_ssid_o,
    output logic                     resp_hit_o,
    output logic                     hnm_write_o,
    output logic [SSIDBITS-1:0]      hnm_ssid_write_o,
    output logic [ROWBITS-1:0]       hnm_row_read_o,
    output logic                     hnm_read_o,
    output logic [SSIDBITS-1:0]      hnm_ssid_read_o,
    input  logic                     hnm_busy_i,
    input  logic                     hnm_write_ready_i,
    input  logic                     hnm_read_ready_i,
    input  logic [SSIDBITS-1:0]      hnm_ssid_passed_i,
    input  logic                     hnm_read_output_i,
    output logic [7:0]               drop_count_o
`ifdef HNM_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]       grant_count_o,
    output logic [15:0]              hazard_stalls_o
`endif
);
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTRW-1:0]          ptr_q, ptr_d;
    logic                     busy_q;
    logic [HAZARD_WINDOW-1:0] haz_v_q;
    logic [ROWBITS-1:0]       haz_row_q [HAZARD_WINDOW];
    logic [READ_LATENCY-1:0]  tag_v_q;
    logic [PTRW-1:0]          tag_id_q [READ_LATENCY];

    logic                     hnm_write_q, hnm_read_q;
    logic [SSIDBITS-1:0]      hnm_ssid_write_q, hnm_ssid_read_q;
    logic [ROWBITS-1:0]       hnm_row_q;
    logic [NREQ-1:0]          resp_valid_q;
    logic [SSIDBITS-1:0]      resp_ssid_q;
    logic                     resp_hit_q;
    logic [7:0]               drop_q;

    logic [ROWBITS-1:0]       req_row [NREQ];
    logic [NREQ-1:0]          hazard_hit, elig;
    logic                     grant, win_write, flush;
    logic [PTRW-1:0]          win;
    logic [SSIDBITS-1:0]      win_ssid;
    logic [8:0]               drop_sum;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_row[i]    = req_ssid_i[i*SSIDBITS + SSIDBITS - 1 -: ROWBITS];
            hazard_hit[i] = 1'b0;
            for (int h = 0; h < HAZARD_WINDOW; h++) begin
                if (haz_v_q[h] && (haz_row_q[h] == req_row[i])) hazard_hit[i] = 1'b1;
            end
            elig[i] = req_valid_i[i] && !hnm_busy_i &&
                      (req_write_i[i] ? hnm_write_ready_i
                                      : (hnm_read_ready_i && !hazard_hit[i]));
        end
    end

    always_comb begin : p_arb
        int idx;
        idx         = 0;
        grant       = 1'b0;
        win         = '0;
        req_ready_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!grant && elig[idx]) begin
                grant = 1'b1;
                win   = PTRW'(idx);
            end
        end
        if (grant) req_ready_o[win] = 1'b1;
        win_write = req_write_i[win];
        win_ssid  = req_ssid_i[int'(win)*SSIDBITS +: SSIDBITS];
        ptr_d     = ptr_q;
        if (grant) ptr_d = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end

    // A rising hnm_busy means the HNM is resetting/filling: in-flight reads are lost.
    always_comb begin : p_drop
        int n;
        n     = 0;
        flush = hnm_busy_i && !busy_q;
        for (int t = 0; t < READ_LATENCY; t++) begin
            if (tag_v_q[t]) n = n + 1;
        end
        drop_sum = {1'b0, drop_q} + 9'(n);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ptr_q            <= '0;
            busy_q           <= 1'b0;
            haz_v_q          <= '0;
            tag_v_q          <= '0;
            for (int h = 0; h < HAZARD_WINDOW; h++) haz_row_q[h] <= '0;
            for (int t = 0; t < READ_LATENCY; t++) tag_id_q[t] <= '0;
            hnm_write_q      <= 1'b0;
            hnm_read_q       <= 1'b0;
            hnm_ssid_write_q <= '0;
            hnm_ssid_read_q  <= '0;
            hnm_row_q        <= '0;
            resp_valid_q     <= '0;
            resp_ssid_q      <= '0;
            resp_hit_q       <= 1'b0;
            drop_q           <= '0;
        end else begin
            ptr_q       <= ptr_d;
            busy_q      <= hnm_busy_i;
            hnm_write_q <= grant && win_write;
            hnm_read_q  <= grant && !win_write;
            if (grant) begin
                hnm_row_q <= win_ssid[SSIDBITS-1 -: ROWBITS];
                if (win_write) hnm_ssid_write_q <= win_ssid;
                else           hnm_ssid_read_q  <= win_ssid;
            end

            haz_v_q[0]   <= grant && win_write;
            haz_row_q[0] <= win_ssid[SSIDBITS-1 -: ROWBITS];
            for (int h = 1; h < HAZARD_WINDOW; h++) begin
                haz_v_q[h]   <= haz_v_q[h-1] && !flush;
                haz_row_q[h] <= haz_row_q[h-1];
            end

            tag_v_q[0]  <= grant && !win_write;
            tag_id_q[0] <= win;
            for (int t = 1; t < READ_LATENCY; t++) begin
                tag_v_q[t]  <= tag_v_q[t-1] && !flush;
                tag_id_q[t] <= tag_id_q[t-1];
            end

            resp_valid_q <= '0;
            if (tag_v_q[READ_LATENCY-1] && !flush) begin
                resp_valid_q[tag_id_q[READ_LATENCY-1]] <= 1'b1;
                resp_ssid_q <= hnm_ssid_passed_i;
                resp_hit_q  <= hnm_read_output_i;
            end
            if (flush) drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign hnm_write_o      = hnm_write_q;
    assign hnm_read_o       = hnm_read_q;
    assign hnm_ssid_write_o = hnm_ssid_write_q;
    assign hnm_ssid_read_o  = hnm_ssid_read_q;
    assign hnm_row_read_o   = hnm_row_q;
    assign resp_valid_o     = resp_valid_q;
    assign resp_ssid_o      = resp_ssid_q;
    assign resp_hit_o       = resp_hit_q;
    assign drop_count_o     = drop_q;

`ifdef HNM_ARB_STATS_EN
    logic [15:0] gcnt_q [NREQ];
    logic [15:0] stall_q;
    logic        stall_cyc;

    always_comb begin
        stall_cyc = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid_i[i] && !req_write_i[i] && !hnm_busy_i && hnm_read_ready_i &&
                hazard_hit[i]) stall_cyc = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NREQ; i++) gcnt_q[i] <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant && (win == PTRW'(i)) && (gcnt_q[i] != 16'hFFFF))
                    gcnt_q[i] <= gcnt_q[i] + 16'd1;
            end
            if (stall_cyc && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_gcnt
        assign grant_count_o[i*16 +: 16] = gcnt_q[i];
    end
    assign hazard_stalls_o = stall_q;
`endif
endmodule

// File: tb/tb_hnm_request_arbiter.sv
// Self-checking bench for hnm_request_arbiter: vector table, directed corner sequences and
// randomized traffic against a timestamp/queue reference model with a simple HNM echo model.
module tb_hnm_request_arbiter;
    localparam int NREQ = 4;
    localparam int SB   = 12;
    localparam int RB   = 7;
    localparam int RL   = 4;
    localparam int HW   = 4;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid, req_write, req_ready, resp_valid;
    logic [NREQ*SB-1:0] req_ssid;
    logic [SB-1:0]     resp_ssid, hnm_ssid_write, hnm_ssid_read, hnm_ssid_passed;
    logic              resp_hit, hnm_write, hnm_read, hnm_busy;
    logic              hnm_write_ready, hnm_read_ready, hnm_read_output;
    logic [RB-1:0]     hnm_row_read;
    logic [7:0]        drop_count;

    hnm_request_arbiter #(
        .NREQ(NREQ), .SSIDBITS(SB), .ROWBITS(RB), .READ_LATENCY(RL), .HAZARD_WINDOW(HW)
    ) dut (
        .clk_i(clk), .reset_i(reset_n),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_ssid_i(req_ssid),
        .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_ssid_o(resp_ssid),
        .resp_hit_o(resp_hit), .hnm_write_o(hnm_write), .hnm_ssid_write_o(hnm_ssid_write),
        .hnm_row_read_o(hnm_row_read), .hnm_read_o(hnm_read), .hnm_ssid_read_o(hnm_ssid_read),
        .hnm_busy_i(hnm_busy), .hnm_write_ready_i(hnm_write_ready),
        .hnm_read_ready_i(hnm_read_ready), .hnm_ssid_passed_i(hnm_ssid_passed),
        .hnm_read_output_i(hnm_read_output), .drop_count_o(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int cyc; int row; } haz_t;
    typedef struct { int due; int id; logic [SB-1:0] ssid; } rsp_t;
    typedef struct packed {
        logic [3:0] valid; logic [3:0] write;
        logic busy; logic wr_rdy; logic rd_rdy;
        logic [3:0] exp_rdy;
    } vec_t;

    haz_t          haz_q[$];
    rsp_t          rsp_q[$];
    logic [SB-1:0] echo_ring [8];
    int            m_ptr, m_drop, mcyc, last_grant;
    bit            m_prev_busy, m_pw, m_pr;
    logic [SB-1:0] m_issue_ssid;
    logic [3:0]    obs_ready;
    int            n_chk, n_fail;
    vec_t          vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (model cycle %0d, t=%0t)",
                     name, act, exp, mcyc, $time);
        end
    endtask

    function automatic logic [SB-1:0] ssid_of(input int i);
        return req_ssid[i*SB +: SB];
    endfunction

    function automatic int row_of(input logic [SB-1:0] s);
        return int'(s[SB-1 -: RB]);
    endfunction

    task automatic set_ssid(input int i, input logic [SB-1:0] s);
        req_ssid[i*SB +: SB] = s;
    endtask

    function automatic logic [SB-1:0] table_ssid(input int i);
        logic [SB-1:0] s;
        s = SB'(((i + 1) << 5) | i);
        return s;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_drop = 0; m_prev_busy = 0; m_pw = 0; m_pr = 0;
        m_issue_ssid = '0; last_grant = -1;
        haz_q.delete(); rsp_q.delete();
        for (int k = 0; k < 8; k++) echo_ring[k] = '0;
    endtask

    // Rule-level model: a row written in cycle g blocks reads in cycles g+1 .. g+HW.
    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            bit ok;
            i = (m_ptr + k) % NREQ;
            if (!req_valid[i] || hnm_busy) continue;
            if (req_write[i]) ok = hnm_write_ready;
            else begin
                ok = hnm_read_ready;
                foreach (haz_q[j]) begin
                    if ((mcyc - haz_q[j].cyc) >= 1 && (mcyc - haz_q[j].cyc) <= HW &&
                        haz_q[j].row == row_of(ssid_of(i))) ok = 0;
                end
            end
            if (ok) return i;
        end
        return -1;
    endfunction

    // One clock cycle: entered just after a falling edge with inputs already applied.
    task automatic step();
        int g;
        logic [3:0] exp_rdy, exp_rv;
        logic [SB-1:0] exp_rs;
        rsp_t keep[$];
        hnm_ssid_passed = echo_ring[(mcyc + 5) % 8];
        hnm_read_output = ^hnm_ssid_passed;
        #1;
        g = model_grant();
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        obs_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("hnm_write", 32'(hnm_write), 32'(m_pw));
        chk("hnm_read", 32'(hnm_read), 32'(m_pr));
        if (m_pw) chk("hnm_ssid_write", 32'(hnm_ssid_write), 32'(m_issue_ssid));
        if (m_pr) chk("hnm_ssid_read", 32'(hnm_ssid_read), 32'(m_issue_ssid));
        if (m_pw || m_pr) chk("hnm_row_read", 32'(hnm_row_read), 32'(row_of(m_issue_ssid)));
        exp_rv = '0; exp_rs = '0;
        foreach (rsp_q[j]) if (rsp_q[j].due == mcyc) begin
            exp_rv = 4'(1 << rsp_q[j].id); exp_rs = rsp_q[j].ssid;
        end
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv != 0) begin
            chk("resp_ssid", 32'(resp_ssid), 32'(exp_rs));
            chk("resp_hit", 32'(resp_hit), 32'(^exp_rs));
        end
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        echo_ring[mcyc % 8] = hnm_read ? hnm_ssid_read : '0;

        foreach (rsp_q[j]) begin
            if (rsp_q[j].due <= mcyc) continue;
            if (hnm_busy && !m_prev_busy) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else keep.push_back(rsp_q[j]);
        end
        rsp_q = keep;
        if (hnm_busy && !m_prev_busy) haz_q.delete();
        m_prev_busy = hnm_busy;
        while (haz_q.size() > 0 && (mcyc - haz_q[0].cyc) >= HW) void'(haz_q.pop_front());
        m_pw = 0; m_pr = 0;
        if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            m_issue_ssid = ssid_of(g);
            if (req_write[g]) begin
                m_pw = 1;
                haz_q.push_back('{mcyc, row_of(ssid_of(g))});
            end else begin
                m_pr = 1;
                rsp_q.push_back('{mcyc + 1 + RL, g, ssid_of(g)});
            end
        end
        last_grant = g;
        mcyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset between edges; called just after a falling edge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_hnm_read", 32'(hnm_read), 32'd0);
        chk("rst_hnm_write", 32'(hnm_write), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic idle(input int n);
        req_valid = '0; req_write = '0; hnm_busy = 0;
        hnm_read_ready = 1; hnm_write_ready = 1;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [3:0] act;
        n_chk = 0; n_fail = 0; mcyc = 0;
        reset_n = 1'b0;
        req_valid = '0; req_write = '0; req_ssid = '0;
        hnm_busy = 0; hnm_write_ready = 1; hnm_read_ready = 1;
        hnm_ssid_passed = '0; hnm_read_output = 0;
        model_reset();
        @(negedge clk);
        chk("reset_hnm_read", 32'(hnm_read), 32'd0);
        chk("reset_hnm_write", 32'(hnm_write), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // valid, write, busy, wr_rdy, rd_rdy, expected req_ready (pointer starts at 0)
        vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000};
        vecs[1]  = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0001};
        vecs[2]  = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0010};
        vecs[3]  = '{4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0001};
        vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000};
        vecs[5]  = '{4'b1111, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010};
        vecs[6]  = '{4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b1000};
        vecs[7]  = '{4'b0110, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0100};
        vecs[8]  = '{4'b0011, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0001};
        vecs[9]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000};
        vecs[10] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0010};
        vecs[11] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0000};
        for (int i = 0; i < NREQ; i++) set_ssid(i, table_ssid(i));
        for (int v = 0; v < 12; v++) begin
            req_valid = vecs[v].valid; req_write = vecs[v].write; hnm_busy = vecs[v].busy;
            hnm_write_ready = vecs[v].wr_rdy; hnm_read_ready = vecs[v].rd_rdy;
            step();
            chk($sformatf("vec%0d_ready", v), 32'(obs_ready), 32'(vecs[v].exp_rdy));
        end
        idle(6);
        chk("vec_drop_count", 32'(drop_count), 32'd3);

        // single read round trip
        do_reset();
        req_valid = 4'b0001; req_write = '0; set_ssid(0, 12'h0A5);
        step();
        chk("single_grant", 32'(obs_ready), 32'h1);
        req_valid = '0;
        #1;
        chk("single_hnm_read", 32'(hnm_read), 32'd1);
        chk("single_hnm_ssid", 32'(hnm_ssid_read), 32'h0A5);
        for (int k = 0; k < 4; k++) step();
        #1;
        chk("single_resp_valid", 32'(resp_valid), 32'h1);
        chk("single_resp_ssid", 32'(resp_ssid), 32'h0A5);
        idle(2);

        // read-after-write hazard on row 9
        do_reset();
        req_valid = 4'b0010; req_write = 4'b0010; set_ssid(1, 12'h123);
        step();
        chk("haz_write_grant", 32'(obs_ready), 32'h2);
        req_valid = 4'b1100; req_write = '0; set_ssid(2, 12'h120); set_ssid(3, 12'h200);
        step();
        chk("haz_other_row", 32'(obs_ready), 32'h8);
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("haz_blocked_%0d", k + 2), 32'(obs_ready), 32'h0);
        end
        step();
        chk("haz_released", 32'(obs_ready), 32'h4);
        idle(6);

        // ready/busy gating
        do_reset();
        hnm_read_ready = 0; hnm_write_ready = 1;
        req_valid = 4'b0011; req_write = 4'b0010; set_ssid(0, 12'h0A5); set_ssid(1, 12'h321);
        step();
        chk("gate_write_only", 32'(obs_ready), 32'h2);
        hnm_busy = 1;
        step();
        chk("gate_busy", 32'(obs_ready), 32'h0);
        idle(6);

        // fairness, then asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ssid(i, table_ssid(i));
        req_valid = 4'b1111; req_write = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("fair_%0d", k), 32'(obs_ready), 32'(1 << (k % 4)));
        end
        req_valid = 4'b0010;
        step();
        #1;
        chk("pre_rst_hnm_read", 32'(hnm_read), 32'd1);
        chk("pre_rst_resp_valid", 32'(resp_valid), 32'h1);
        do_reset();
        req_valid = 4'b1111;
        step();
        chk("post_rst_ptr", 32'(obs_ready), 32'h1);
        idle(6);

        // randomized traffic
        do_reset();
        act = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!act[i] && $urandom_range(0, 2) == 0) begin
                    act[i] = 1'b1;
                    req_write[i] = ($urandom_range(0, 3) == 0);
                    set_ssid(i, {7'($urandom_range(0, 5)), 5'($urandom)});
                end
            end
            req_valid = act;
            hnm_busy = ($urandom_range(0, 39) == 0) ? 1'b1 : (hnm_busy && $urandom_range(0, 2) != 0);
            hnm_read_ready = ($urandom_range(0, 4) != 0);
            hnm_write_ready = ($urandom_range(0, 4) != 0);
            step();
            if (last_grant >= 0) act[last_grant] = 1'b0;
        end
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, test did not complete");
        $fatal(1, "watchdog");
    end
endmodule
